// File: rtl/rbm_bernoulli_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rbm_bernoulli_sampler
// Purpose  : Stochastic binary neuron. Compares a sigmoid probability against
//            a Galois-LFSR draw (or a fixed 0.5 threshold) to emit 0/1 samples.
// Revision : 1.0 - initial release
// ============================================================================
module rbm_bernoulli_sampler #(
    parameter int          N_OUT     = 16,
    parameter int          P_OUT     = 15,
    parameter int          N_NEURONS = 64,
    parameter int          IDX_W     = 6,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             det_mode,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_OUT-1:0] prob,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);

    // Compare in a width wide enough for both the probability and the draw.
    localparam int               CW           = (N_OUT > P_OUT) ? N_OUT : P_OUT;
    localparam logic [31:0]      c_LFSR_MASK  = 32'h8020_0003;
    localparam logic [CW-1:0]    c_HALF       = CW'(64'd1 << (P_OUT - 1));
    localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(N_NEURONS - 1);

    logic [31:0]      r_lfsr;
    logic [IDX_W-1:0] r_idx;
    logic             r_out_valid;
    logic             r_out_bit;
    logic [IDX_W-1:0] r_out_index;
    logic             r_out_last;

    logic             w_accept;
    logic [31:0]      w_lfsr_next;
    logic [31:0]      w_seed_value;
    logic [CW-1:0]    w_rand;
    logic [CW-1:0]    w_prob;
    logic             w_sample;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_idx_is_last;

    assign in_ready = !seed_load && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_lfsr_next = r_lfsr >> 1;
        if (r_lfsr[0]) begin
            w_lfsr_next = (r_lfsr >> 1) ^ c_LFSR_MASK;
        end
    end

    // A zero seed would lock the LFSR, so it is redirected to the default.
    assign w_seed_value = (seed == 32'd0) ? LFSR_SEED : seed;

    assign w_rand   = CW'(r_lfsr[P_OUT-1:0]);
    assign w_prob   = CW'(prob);
    assign w_sample = det_mode ? (w_prob >= c_HALF) : (w_rand < w_prob);

    assign w_idx_is_last = (r_idx == c_LAST_IDX);
    assign w_idx_next    = w_idx_is_last ? '0 : r_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else if (seed_load) begin
            r_lfsr <= w_seed_value;
        end else if (w_accept) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_idx_next;
        end
    end

    // Single output stage; data registers only move on an accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_bit   <= w_sample;
            r_out_index <= r_idx;
            r_out_last  <= w_idx_is_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_bit   = r_out_bit;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;

endmodule
`default_nettype wire

// File: doc/rbm_bernoulli_sampler.md
# rbm_bernoulli_sampler

Stochastic binary-neuron stage that sits directly downstream of `sigmoid_func` in the RBM Gibbs-sampling datapath. It accepts one unsigned sigmoid probability per cycle. It compares that probability against a uniform pseudo-random number from an internal 32-bit Galois LFSR and emits the sampled neuron state, a 0/1 bit, tagged with its neuron index and an end-of-layer flag. A deterministic mode replaces the random draw with a fixed 0.5 threshold, for mean-field or debug runs.

## Interface
Parameters:
- `N_OUT`, 16: probability input width; must match the sigmoid output width.
- `P_OUT`, 15: fractional bits of the probability; 1.0 = `1 << P_OUT`. Legal range is 1..31.
- `N_NEURONS`, 64: neurons per layer; sets the index wrap point. Must be ≥ 2.
- `IDX_W`, 6: index width; must satisfy ≥ clog2(`N_NEURONS`).
- `LFSR_SEED`, 32'hACE1_2468: LFSR reset and default seed; must be nonzero.

Ports:
- `clk`, in, 1: the block's single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `det_mode`, in, 1: 1 = threshold at 0.5; 0 = stochastic sampling.
- `seed_load`, in, 1: reseed the LFSR from `seed`.
- `seed`, in, 32: new LFSR state; the value 0 maps to `LFSR_SEED`.
- `in_valid`, in, 1: `prob` is valid.
- `in_ready`, out, 1: the block can accept `prob` this cycle.
- `prob`, in, `N_OUT`: unsigned sigmoid probability.
- `out_valid`, out, 1: the output sample is valid.
- `out_ready`, in, 1: the consumer accepts the output this cycle.
- `out_bit`, out, 1: sampled neuron state.
- `out_index`, out, `IDX_W`: neuron index of `out_bit`.
- `out_last`, out, 1: asserted when `out_index` = `N_NEURONS`-1.

## Operation
- **Handshake.** An input is accepted on a rising edge when `in_valid && in_ready`. An output is consumed when `out_valid && out_ready`.
- **`in_ready`.** Equals `!seed_load && (!out_valid || out_ready)`. It has a combinational path from `out_ready` and `seed_load`.
- **Random draw.** `rand` = LFSR[`P_OUT`-1:0], zero-extended to `N_OUT` bits.
- **Stochastic mode.** `out_bit` = (`rand` < `prob`).
  - `prob` = 0 always gives 0.
  - `prob` ≥ `1 << P_OUT` always gives 1.
  - `prob` = 1 LSB gives 1 with probability 2^-`P_OUT`.
- **Deterministic mode.** `out_bit` = (`prob` ≥ `1 << (P_OUT-1)`).
- **LFSR.** Galois right-shift, polynomial x^32+x^22+x^2+x+1, feedback mask 32'h8020_0003.
  - Update: if lsb = 1, next = (state >> 1) ^ mask; otherwise next = state >> 1.
  - It advances exactly once per accepted input, in both modes.
  - The draw for an input uses the pre-advance state.
  - It never reaches the all-zero state.
- **Reseed.** `seed_load` = 1 loads `seed`, or `LFSR_SEED` if `seed` = 0, on the next edge.
  - No input is accepted that cycle.
  - A pending output is unaffected and can still be consumed.
- **Index counter.**
  - Increments on each accepted input and wraps from `N_NEURONS`-1 to 0.
  - `out_index` carries the counter value at acceptance.
  - The counter never changes while inputs are stalled.
- **Output register.** A single register stage. While `out_valid` = 1 and `out_ready` = 0, `out_bit`, `out_index` and `out_last` hold stable.

## Timing
- **Reset.** `rst` asserted asynchronously gives:
  - `out_valid` = 0, `out_bit` = 0, `out_index` = 0, `out_last` = 0;
  - index counter = 0, LFSR = `LFSR_SEED`.
  - `in_ready` = 1 once `rst` is low, provided `seed_load` = 0.
- **Latency.** One cycle from the accept edge to `out_valid` = 1 with the result.
- **Throughput.** One sample per cycle when `out_ready` is held at 1.
- **Simultaneous consume and accept.** When `out_valid && out_ready && in_valid`, the old sample retires and the new one loads on the same edge. No bubble.
- **Consume without a new input.** `out_valid` falls on the next edge.
- **Mid-stream reset.** Any in-flight sample is dropped. The index restarts at 0 and the LFSR restarts at `LFSR_SEED`. The next accepted input is index 0.
- **`det_mode`.** Sampled at the accept edge. A change mid-layer affects only later inputs.

## Test plan
- **Reset values.** Assert `rst` asynchronously mid-cycle.
  - Expect: all outputs 0 immediately and LFSR = 32'hACE1_2468.
  - Expect: after release, `in_ready` = 1.
- **Saturated probabilities.** Stream 64 × `prob` = 16'h8000, then 64 × `prob` = 0, with `out_ready` = 1.
  - Expect: 64 ones, then 64 zeros.
  - Expect: indices 0..63 twice, `out_last` only at index 63.
  - Expect: exactly one cycle of latency.
- **Statistics and golden LFSR.** Stream 4096 × `prob` = 16'h4000.
  - Expect: ones count within 2048±128.
  - Expect: every `out_bit` matches a reference Galois-LFSR model seeded with 32'hACE1_2468.
- **Backpressure.** Hold `out_ready` = 0 for 5 cycles while `in_valid` = 1.
  - Expect: `in_ready` = 0 and the output holds stable.
  - Expect: after release, no sample is lost or duplicated and the indices are contiguous.
- **Deterministic mode.** `det_mode` = 1 with `prob` values 16'h3FFF, 16'h4000, 16'h8000.
  - Expect: `out_bit` = 0, 1, 1.
  - Expect: the LFSR still advances 3 steps.
- **Reseed.** `seed_load` = 1 with `seed` = 0 while `in_valid` = 1.
  - Expect: no accept that cycle and LFSR = `LFSR_SEED`.
  - Expect: following samples replay the post-reset sequence.
